// File: rtl/cpu_mem_pkg.sv
// ---------------------------------------------------------------------------
// cpu_mem_pkg
// Shared constants and types for the CPU memory-bus initiator.
//   ADDR_W / DATA_W / MEM_DEPTH : default bus geometry
//   state_t                     : controller FSM encoding
//   SRC_FETCH / SRC_DATA        : requester ids, also the bit index of each
//                                 requester inside the one-hot grant vector
// ---------------------------------------------------------------------------
package cpu_mem_pkg;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 16;
    localparam int MEM_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic SRC_FETCH = 1'b0;
    localparam logic SRC_DATA  = 1'b1;

    // Collapse a one-hot grant into a source id. An all-zero grant maps to
    // SRC_FETCH, which callers never consume because no accept can occur.
    function automatic logic src_from_grant(input logic [1:0] grant);
        return grant[SRC_DATA] ? SRC_DATA : SRC_FETCH;
    endfunction

endpackage

// File: rtl/mem_rr_arb.sv
// ---------------------------------------------------------------------------
// mem_rr_arb
// Two-requester round-robin arbiter for the fetch and data ports.
// The grant is purely combinational from the two valids; the last-granted
// pointer advances only when the requester actually hands off (accept).
// Ports:
//   CLK          in   system clock
//   reset        in   synchronous active-high reset
//   fetch_valid  in   fetch port is requesting
//   data_valid   in   data port is requesting
//   accept       in   a grant was consumed this cycle (valid && ready)
//   grant        out  one-hot grant, bit SRC_FETCH / bit SRC_DATA
// ---------------------------------------------------------------------------
module mem_rr_arb
    import cpu_mem_pkg::*;
(
    input  logic       CLK,
    input  logic       reset,
    input  logic       fetch_valid,
    input  logic       data_valid,
    input  logic       accept,
    output logic [1:0] grant
);

    // Reset to "fetch went last" so the data port wins the first tie.
    logic last_q;

    always_comb begin
        grant = 2'b00;
        if (fetch_valid && data_valid) begin
            if (last_q == SRC_FETCH) begin
                grant[SRC_DATA] = 1'b1;
            end else begin
                grant[SRC_FETCH] = 1'b1;
            end
        end else if (fetch_valid) begin
            grant[SRC_FETCH] = 1'b1;
        end else if (data_valid) begin
            grant[SRC_DATA] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            last_q <= SRC_FETCH;
        end else if (accept) begin
            last_q <= src_from_grant(grant);
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
// Initiator side of the CPU memory bus. Arbitrates fetch (read-only) and data
// (load/store) requests, sequences the memory's one-cycle registered read
// latency and returns exactly one response pulse to the requesting port.
//
// State table:
//   state | meaning
//   IDLE  | waiting for a request; arbitration and accept happen here
//   ISSUE | ADDR/Mem_wdata valid, MemRead or MemWrite strobed for one cycle
//   WAIT  | memory read data appears on Mem_rdata, captured at cycle end
//
// Latency from accept edge to rsp_valid: load/fetch 3, store 2, error 1.
//
// Ports:
//   CLK, reset                       clock, synchronous active-high reset
//   if_req_valid/ready, if_addr      fetch request handshake
//   if_rsp_valid/data/err            fetch response pulse
//   d_req_valid/ready/we, d_addr,
//   d_wdata                          data request handshake
//   d_rsp_valid/data/err             data response pulse (load data / ack)
//   MemRead, MemWrite, ADDR,
//   Mem_wdata                        memory command side
//   Mem_rdata                        registered memory read data
//   busy                             high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int ADDR_W    = cpu_mem_pkg::ADDR_W,
    parameter int DATA_W    = cpu_mem_pkg::DATA_W,
    parameter int MEM_DEPTH = cpu_mem_pkg::MEM_DEPTH
) (
    input  logic              CLK,
    input  logic              reset,

    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    output logic              if_rsp_err,

    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_req_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rsp_data,
    output logic              d_rsp_err,

    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] Mem_wdata,
    input  logic [DATA_W-1:0] Mem_rdata,

    output logic              busy
);

    import cpu_mem_pkg::*;

    state_t state_q;
    state_t state_d;

    logic       we_q;
    logic       src_q;
    logic [1:0] grant;

    logic              if_acc;
    logic              d_acc;
    logic              accept;
    logic [ADDR_W-1:0] acc_addr;
    logic              acc_in_range;

    mem_rr_arb u_arb (
        .CLK         (CLK),
        .reset       (reset),
        .fetch_valid (if_req_valid),
        .data_valid  (d_req_valid),
        .accept      (accept),
        .grant       (grant)
    );

    assign if_acc   = if_req_valid && if_req_ready;
    assign d_acc    = d_req_valid && d_req_ready;
    assign accept   = if_acc || d_acc;
    assign acc_addr = d_acc ? d_addr : if_addr;

    // Extra bit so a MEM_DEPTH equal to 2**ADDR_W still compares correctly.
    assign acc_in_range = ({1'b0, acc_addr} < (ADDR_W+1)'(MEM_DEPTH));

    assign busy = (state_q != IDLE);

    // Next state plus the combinational handshake and memory strobes.
    // Everything that can reach the memory is masked by reset, because the
    // memory keeps honouring MemWrite while it is itself in reset.
    always_comb begin
        state_d      = state_q;
        if_req_ready = 1'b0;
        d_req_ready  = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;

        case (state_q)
            IDLE: begin
                if_req_ready = grant[SRC_FETCH] && !reset;
                d_req_ready  = grant[SRC_DATA]  && !reset;
                // Out-of-range accepts are answered from IDLE directly.
                if (accept && acc_in_range) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                MemRead  = !we_q && !reset;
                MemWrite =  we_q && !reset;
                state_d  = we_q ? IDLE : WAIT;
            end
            WAIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            src_q        <= SRC_FETCH;
            ADDR         <= '0;
            Mem_wdata    <= '0;
            if_rsp_valid <= 1'b0;
            if_rsp_err   <= 1'b0;
            if_rsp_data  <= '0;
            d_rsp_valid  <= 1'b0;
            d_rsp_err    <= 1'b0;
            d_rsp_data   <= '0;
        end else begin
            state_q <= state_d;

            // Responses are single-cycle pulses; clear unless set below.
            if_rsp_valid <= 1'b0;
            if_rsp_err   <= 1'b0;
            if_rsp_data  <= '0;
            d_rsp_valid  <= 1'b0;
            d_rsp_err    <= 1'b0;
            d_rsp_data   <= '0;

            if (accept) begin
                if (acc_in_range) begin
                    // ADDR doubles as the latched address; it only moves on
                    // an in-range accept, so it holds outside ISSUE.
                    ADDR  <= acc_addr;
                    we_q  <= d_acc && d_req_we;
                    src_q <= d_acc ? SRC_DATA : SRC_FETCH;
                    if (d_acc) begin
                        Mem_wdata <= d_wdata;
                    end
                end else if (d_acc) begin
                    d_rsp_valid <= 1'b1;
                    d_rsp_err   <= 1'b1;
                end else begin
                    if_rsp_valid <= 1'b1;
                    if_rsp_err   <= 1'b1;
                end
            end

            // Store ack: only the data port can issue a write.
            if (state_q == ISSUE && we_q) begin
                d_rsp_valid <= 1'b1;
            end

            if (state_q == WAIT) begin
                if (src_q == SRC_DATA) begin
                    d_rsp_valid <= 1'b1;
                    d_rsp_data  <= Mem_rdata;
                end else begin
                    if_rsp_valid <= 1'b1;
                    if_rsp_data  <= Mem_rdata;
                end
            end
        end
    end

endmodule
